// File: rtl/execute_stage_if.sv
// Bus between the pipeline control/decode side and the Y86-64 execute stage.
// The slave modport is the execute stage's view; master is the driver's view.
interface execute_stage_if #(
  parameter int DATA_W = 64
);
  logic              stall_i;
  logic              bubble_i;
  logic [3:0]        icode_i;
  logic [3:0]        ifun_i;
  logic [2:0]        stat_i;
  logic [DATA_W-1:0] valA_i;
  logic [DATA_W-1:0] valB_i;
  logic [DATA_W-1:0] valC_i;
  logic [3:0]        dstE_i;
  logic [3:0]        dstM_i;
  logic [2:0]        m_stat_i;
  logic [2:0]        W_stat_i;
  logic [3:0]        icode_o;
  logic [2:0]        stat_o;
  logic              cnd_o;
  logic [DATA_W-1:0] valE_o;
  logic [DATA_W-1:0] valA_o;
  logic [3:0]        dstE_o;
  logic [3:0]        dstM_o;
  logic [DATA_W-1:0] fwd_valE_o;
  logic [3:0]        fwd_dstE_o;

  modport slave (
    input  stall_i, bubble_i, icode_i, ifun_i, stat_i, valA_i, valB_i, valC_i,
           dstE_i, dstM_i, m_stat_i, W_stat_i,
    output icode_o, stat_o, cnd_o, valE_o, valA_o, dstE_o, dstM_o,
           fwd_valE_o, fwd_dstE_o
  );

  modport master (
    output stall_i, bubble_i, icode_i, ifun_i, stat_i, valA_i, valB_i, valC_i,
           dstE_i, dstM_i, m_stat_i, W_stat_i,
    input  icode_o, stat_o, cnd_o, valE_o, valA_o, dstE_o, dstM_o,
           fwd_valE_o, fwd_dstE_o
  );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and cnd.
// Optional macro EXEC_FWD_EN drives the decode bypass copies of valE/dstE.
module execute_stage #(
  parameter int         DATA_W   = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic           clk_i,
  input  logic           rst_i,
  execute_stage_if.slave bus
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] A_ADD = 4'h0;
  localparam logic [3:0] A_SUB = 4'h1;
  localparam logic [3:0] A_AND = 4'h2;
  localparam logic [3:0] A_XOR = 4'h3;

  localparam logic [3:0] RNONE      = 4'hF;
  localparam logic [2:0] STAT_BUBBLE = 3'd0;
  localparam logic [2:0] STAT_HLT    = 3'd2;
  localparam logic [2:0] STAT_ADR    = 3'd3;
  localparam logic [2:0] STAT_INS    = 3'd4;

  localparam logic [DATA_W-1:0] EIGHT = DATA_W'(8);

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [2:0]        stat;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] val_c;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
  } ereg_t;

  localparam ereg_t E_BUBBLE = '{
    icode: I_NOP, ifun: 4'h0, stat: STAT_BUBBLE,
    val_a: '0, val_b: '0, val_c: '0, dst_e: RNONE, dst_m: RNONE
  };

  function automatic logic is_exception(input logic [2:0] stat);
    return (stat == STAT_ADR) || (stat == STAT_INS) || (stat == STAT_HLT);
  endfunction

  // cc is {ZF,SF,OF}
  function automatic logic cond_eval(input logic [3:0] fun, input logic [2:0] cc);
    logic zf, sf, of;
    logic res;
    {zf, sf, of} = cc;
    case (fun)
      4'h0:    res = 1'b1;
      4'h1:    res = (sf ^ of) | zf;
      4'h2:    res = sf ^ of;
      4'h3:    res = zf;
      4'h4:    res = ~zf;
      4'h5:    res = ~(sf ^ of);
      4'h6:    res = ~(sf ^ of) & ~zf;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  ereg_t             e_q, e_d;
  logic [2:0]        cc_q, cc_d;
  logic [DATA_W-1:0] alu_a_s, alu_b_s, val_e_s;
  logic [3:0]        alu_fun_s;
  logic              of_s, cc_en_s, cnd_s;
  logic [3:0]        dst_e_s;

  // E register next state: stall holds, bubble injects a NOP
  always_comb begin
    e_d = e_q;
    if (bus.stall_i) begin
      e_d = e_q;
    end else if (bus.bubble_i) begin
      e_d = E_BUBBLE;
    end else begin
      e_d = '{
        icode: bus.icode_i, ifun: bus.ifun_i, stat: bus.stat_i,
        val_a: bus.valA_i, val_b: bus.valB_i, val_c: bus.valC_i,
        dst_e: bus.dstE_i, dst_m: bus.dstM_i
      };
    end
  end

  // E register state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e_q <= E_BUBBLE;
    end else begin
      e_q <= e_d;
    end
  end

  // ALU operand selection
  always_comb begin
    alu_a_s = '0;
    alu_b_s = '0;
    case (e_q.icode)
      I_RRMOVQ, I_OPQ:             alu_a_s = e_q.val_a;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_s = e_q.val_c;
      I_CALL, I_PUSHQ:             alu_a_s = -EIGHT;
      I_RET, I_POPQ:               alu_a_s = EIGHT;
      default:                     alu_a_s = '0;
    endcase
    case (e_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b_s = e_q.val_b;
      default:                                                   alu_b_s = '0;
    endcase
  end

  // ALU function and signed-overflow detection
  always_comb begin
    alu_fun_s = (e_q.icode == I_OPQ) ? e_q.ifun : A_ADD;
    val_e_s   = '0;
    of_s      = 1'b0;
    case (alu_fun_s)
      A_ADD: begin
        val_e_s = alu_b_s + alu_a_s;
        of_s    = (alu_a_s[DATA_W-1] == alu_b_s[DATA_W-1]) &&
                  (val_e_s[DATA_W-1] != alu_a_s[DATA_W-1]);
      end
      A_SUB: begin
        val_e_s = alu_b_s - alu_a_s;
        of_s    = (alu_a_s[DATA_W-1] != alu_b_s[DATA_W-1]) &&
                  (val_e_s[DATA_W-1] != alu_b_s[DATA_W-1]);
      end
      A_AND:   val_e_s = alu_b_s & alu_a_s;
      A_XOR:   val_e_s = alu_b_s ^ alu_a_s;
      default: val_e_s = '0;
    endcase
  end

  // CC next state; frozen once an exception is further down the pipe
  always_comb begin
    cc_en_s = (e_q.icode == I_OPQ) && !is_exception(bus.m_stat_i) &&
              !is_exception(bus.W_stat_i) && !bus.stall_i;
    if (cc_en_s) begin
      cc_d = {(val_e_s == '0), val_e_s[DATA_W-1], of_s};
    end else begin
      cc_d = cc_q;
    end
  end

  // Condition-code register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  // cnd from the current CC; a false cmov loses its destination
  always_comb begin
    if ((e_q.icode == I_RRMOVQ) || (e_q.icode == I_JXX)) begin
      cnd_s = cond_eval(e_q.ifun, cc_q);
    end else begin
      cnd_s = 1'b1;
    end
    if ((e_q.icode == I_RRMOVQ) && !cnd_s) begin
      dst_e_s = RNONE;
    end else begin
      dst_e_s = e_q.dst_e;
    end
  end

  assign bus.icode_o = e_q.icode;
  assign bus.stat_o  = e_q.stat;
  assign bus.cnd_o   = cnd_s;
  assign bus.valE_o  = val_e_s;
  assign bus.valA_o  = e_q.val_a;
  assign bus.dstE_o  = dst_e_s;
  assign bus.dstM_o  = e_q.dst_m;

`ifdef EXEC_FWD_EN
  assign bus.fwd_valE_o = val_e_s;
  assign bus.fwd_dstE_o = dst_e_s;
`else
  assign bus.fwd_valE_o = '0;
  assign bus.fwd_dstE_o = RNONE;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a reference model predicts each
// E-stage output when stimulus is driven; results are compared one edge later.
module tb_execute_stage;

  localparam int W = 64;
  localparam logic [3:0] I_NOP = 4'h1, I_RRMOVQ = 4'h2, I_IRMOVQ = 4'h3, I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5, I_OPQ = 4'h6, I_JXX = 4'h7, I_CALL = 4'h8;
  localparam logic [3:0] I_RET = 4'h9, I_PUSHQ = 4'hA, I_POPQ = 4'hB, RNONE = 4'hF;
  localparam logic [2:0] S_BUB = 3'd0, S_AOK = 3'd1, S_HLT = 3'd2, S_ADR = 3'd3, S_INS = 3'd4;

  typedef struct packed {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [2:0]   stat;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [3:0]   de;
    logic [3:0]   dm;
  } ereg_t;

  typedef struct packed {
    logic [3:0]   icode;
    logic [2:0]   stat;
    logic         cnd;
    logic [W-1:0] vale;
    logic [W-1:0] vala;
    logic [3:0]   dste;
    logic [3:0]   dstm;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  ereg_t m_e;
  logic [2:0] m_cc;

  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(W)) bus();

  execute_stage #(.DATA_W(W), .CC_RESET(3'b100)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ereg_t bubble_img();
    ereg_t e;
    e.icode = I_NOP; e.ifun = 4'h0; e.stat = S_BUB;
    e.a = '0; e.b = '0; e.c = '0; e.de = RNONE; e.dm = RNONE;
    return e;
  endfunction

  function automatic logic bad(input logic [2:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

  // returns {valE, ZF, SF, OF}
  function automatic logic [W+2:0] ref_alu(input ereg_t e);
    logic [W-1:0] a, b, r;
    logic of;
    logic [3:0] f;
    a = '0; b = '0; r = '0; of = 1'b0;
    if (e.icode == I_RRMOVQ || e.icode == I_OPQ) a = e.a;
    else if (e.icode == I_IRMOVQ || e.icode == I_RMMOVQ || e.icode == I_MRMOVQ) a = e.c;
    else if (e.icode == I_CALL || e.icode == I_PUSHQ) a = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (e.icode == I_RET || e.icode == I_POPQ) a = 64'd8;
    if (e.icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ}) b = e.b;
    f = (e.icode == I_OPQ) ? e.ifun : 4'h0;
    if (f == 4'h0) begin
      r = b + a;
      of = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else if (f == 4'h1) begin
      r = b - a;
      of = (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
    end else if (f == 4'h2) r = b & a;
    else if (f == 4'h3) r = b ^ a;
    return {r, (r == '0), r[W-1], of};
  endfunction

  function automatic logic ref_cnd(input logic [3:0] icode, input logic [3:0] fn, input logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    if (icode != I_RRMOVQ && icode != I_JXX) return 1'b1;
    if (fn == 4'h0) return 1'b1;
    if (fn == 4'h1) return (sf ^ of) | zf;
    if (fn == 4'h2) return sf ^ of;
    if (fn == 4'h3) return zf;
    if (fn == 4'h4) return ~zf;
    if (fn == 4'h5) return ~(sf ^ of);
    if (fn == 4'h6) return ~(sf ^ of) & ~zf;
    return 1'b0;
  endfunction

  task automatic issue(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [3:0] de, input logic [3:0] dm, input logic stall,
                       input logic bubble, input logic [2:0] mst, input logic [2:0] wst);
    logic [W+2:0] r;
    exp_t x;
    bus.icode_i = icode; bus.ifun_i = ifun; bus.stat_i = stat;
    bus.valA_i = a; bus.valB_i = b; bus.valC_i = c;
    bus.dstE_i = de; bus.dstM_i = dm; bus.stall_i = stall; bus.bubble_i = bubble;
    bus.m_stat_i = mst; bus.W_stat_i = wst;
    if (!stall) begin
      if (m_e.icode == I_OPQ && !bad(mst) && !bad(wst)) begin
        r = ref_alu(m_e);
        m_cc = r[2:0];
      end
      if (bubble) m_e = bubble_img();
      else begin
        m_e.icode = icode; m_e.ifun = ifun; m_e.stat = stat;
        m_e.a = a; m_e.b = b; m_e.c = c; m_e.de = de; m_e.dm = dm;
      end
    end
    r = ref_alu(m_e);
    x.icode = m_e.icode; x.stat = m_e.stat; x.vale = r[W+2:3]; x.vala = m_e.a;
    x.cnd = ref_cnd(m_e.icode, m_e.ifun, m_cc);
    x.dste = (m_e.icode == I_RRMOVQ && !x.cnd) ? RNONE : m_e.de;
    x.dstm = m_e.dm;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("icode", W'(bus.icode_o), W'(x.icode));
    check_eq("stat", W'(bus.stat_o), W'(x.stat));
    check_eq("cnd", W'(bus.cnd_o), W'(x.cnd));
    check_eq("valE", bus.valE_o, x.vale);
    check_eq("valA", bus.valA_o, x.vala);
    check_eq("dstE", W'(bus.dstE_o), W'(x.dste));
    check_eq("dstM", W'(bus.dstM_o), W'(x.dstm));
`ifdef EXEC_FWD_EN
    check_eq("fwd_valE", bus.fwd_valE_o, x.vale);
    check_eq("fwd_dstE", W'(bus.fwd_dstE_o), W'(x.dste));
`else
    check_eq("fwd_valE", bus.fwd_valE_o, '0);
    check_eq("fwd_dstE", W'(bus.fwd_dstE_o), W'(RNONE));
`endif
  endtask

  task automatic op(input logic [3:0] icode, input logic [3:0] ifun,
                    input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] de);
    issue(icode, ifun, S_AOK, a, b, 64'h0, de, RNONE, 1'b0, 1'b0, S_AOK, S_AOK);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_icode"}, W'(bus.icode_o), W'(I_NOP));
    check_eq({tag, "_stat"}, W'(bus.stat_o), W'(S_BUB));
    check_eq({tag, "_dstE"}, W'(bus.dstE_o), W'(RNONE));
    check_eq({tag, "_dstM"}, W'(bus.dstM_o), W'(RNONE));
    check_eq({tag, "_valE"}, bus.valE_o, '0);
    check_eq({tag, "_valA"}, bus.valA_o, '0);
    check_eq({tag, "_cnd"}, W'(bus.cnd_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.icode_i = I_NOP; bus.ifun_i = 4'h0; bus.stat_i = S_AOK;
    bus.valA_i = '0; bus.valB_i = '0; bus.valC_i = '0;
    bus.dstE_i = RNONE; bus.dstM_i = RNONE; bus.stall_i = 1'b0; bus.bubble_i = 1'b0;
    bus.m_stat_i = S_AOK; bus.W_stat_i = S_AOK;
    m_e = bubble_img();
    m_cc = 3'b100;
    #22;
    check_reset_state("por");
    @(negedge clk);
    rst = 1'b0;

    // CC reset {ZF,SF,OF}=100: je true, jl false
    op(I_JXX, 4'h3, '0, '0, RNONE);
    check_eq("rst_je", W'(bus.cnd_o), 64'd1);
    op(I_JXX, 4'h2, '0, '0, RNONE);
    check_eq("rst_jl", W'(bus.cnd_o), 64'd0);

    op(I_OPQ, 4'h1, 64'd5, 64'd3, 4'd2);
    check_eq("sub_valE", bus.valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    op(I_RRMOVQ, 4'h2, 64'h77, '0, 4'd4);
    check_eq("cmovl_cnd", W'(bus.cnd_o), 64'd1);

    op(I_OPQ, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'd1);
    check_eq("add_valE", bus.valE_o, 64'hFFFF_FFFF_FFFF_FFFE);
    op(I_JXX, 4'h2, '0, '0, RNONE);
    check_eq("jl_after_of", W'(bus.cnd_o), 64'd0);

    op(I_RRMOVQ, 4'h3, 64'h99, '0, 4'd3);
    check_eq("cmove_squash", W'(bus.dstE_o), W'(RNONE));

    op(I_PUSHQ, 4'h0, 64'h1234, 64'h100, 4'd4);
    check_eq("push_valE", bus.valE_o, 64'hF8);
    op(I_POPQ, 4'h0, '0, 64'hF8, 4'd4);
    check_eq("pop_valE", bus.valE_o, 64'h100);
    op(I_JXX, 4'h2, '0, '0, RNONE);
    check_eq("cc_kept_jl", W'(bus.cnd_o), 64'd0);

    // OPQ XOR giving zero, but writeback holds an address fault
    op(I_OPQ, 4'h3, 64'd7, 64'd7, 4'd1);
    issue(I_JXX, 4'h3, S_AOK, '0, '0, '0, RNONE, RNONE, 1'b0, 1'b0, S_AOK, S_ADR);
    check_eq("gated_je", W'(bus.cnd_o), 64'd0);
    op(I_OPQ, 4'h3, 64'd7, 64'd7, 4'd1);
    op(I_JXX, 4'h3, '0, '0, RNONE);
    check_eq("ungated_je", W'(bus.cnd_o), 64'd1);

    issue(I_IRMOVQ, 4'h0, S_AOK, '0, '0, 64'h55, 4'd2, RNONE, 1'b0, 1'b0, S_AOK, S_AOK);
    for (int i = 0; i < 3; i++)
      issue(I_OPQ, 4'h1, S_INS, 64'(i), 64'h9, '0, 4'd5, 4'd6, 1'b1, 1'b0, S_AOK, S_AOK);
    check_eq("stall_held", W'(bus.icode_o), W'(I_IRMOVQ));
    issue(I_OPQ, 4'h1, S_INS, 64'h1, 64'h9, '0, 4'd5, 4'd6, 1'b1, 1'b1, S_AOK, S_AOK);
    check_eq("stall_bubble_held", bus.valE_o, 64'h55);
    issue(I_OPQ, 4'h1, S_INS, 64'h1, 64'h9, '0, 4'd5, 4'd6, 1'b0, 1'b1, S_AOK, S_AOK);
    check_eq("bubble_icode", W'(bus.icode_o), W'(I_NOP));
    check_eq("bubble_stat", W'(bus.stat_o), W'(S_BUB));

    // reset between edges with a cmov in flight
    op(I_OPQ, 4'h0, 64'd1, 64'd1, 4'd1);
    op(I_RRMOVQ, 4'h0, 64'h42, '0, 4'd3);
    rst = 1'b1;
    #1;
    check_reset_state("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    m_e = bubble_img();
    m_cc = 3'b100;
    op(I_JXX, 4'h1, '0, '0, RNONE);
    check_eq("mid_rst_jle", W'(bus.cnd_o), 64'd1);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] ic;
      logic [2:0] ws;
      case ($urandom_range(0, 5))
        0: ic = I_RRMOVQ;
        1: ic = I_JXX;
        2: ic = I_MRMOVQ;
        3: ic = I_CALL;
        default: ic = I_OPQ;
      endcase
      ws = ($urandom_range(0, 7) == 0) ? S_HLT : S_AOK;
      issue(ic, 4'($urandom_range(0, 8)), S_AOK, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), S_AOK, ws);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
